// File: rtl/start_change_gen.sv
// Start/mode command front end: synchronises and debounces the start button and mode bus,
// emitting one-cycle start and changed pulses. Optional START_PENDING_EN holds one start while busy.
module start_change_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MODE_W          = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              busy,
    output logic              start,
    output logic              changed,
    output logic [MODE_W-1:0] mode_q
);

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic              btn_s1, btn_s2;
    logic [MODE_W-1:0] mode_s1, mode_s2;
    logic [7:0]        btn_cnt, mode_cnt;
    logic              btn_db, btn_db_d;
    logic [MODE_W-1:0] mode_db;
    logic              btn_rise;

    assign btn_rise = btn_db & ~btn_db_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            mode_s1 <= '0;
            mode_s2 <= '0;
        end else begin
            btn_s1  <= btn_start;
            btn_s2  <= btn_s1;
            mode_s1 <= mode_in;
            mode_s2 <= mode_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_cnt <= '0;
            btn_db  <= 1'b0;
        end else if (btn_s2 == btn_db) begin
            btn_cnt <= '0;
        end else if (btn_cnt == LAST) begin
            btn_db  <= btn_s2;
            btn_cnt <= '0;
        end else begin
            btn_cnt <= btn_cnt + 8'd1;
        end
    end

    // Whole-word compare: a value change mid-count keeps counting and loads the latest word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_cnt <= '0;
            mode_db  <= '0;
        end else if (mode_s2 == mode_db) begin
            mode_cnt <= '0;
        end else if (mode_cnt == LAST) begin
            mode_db  <= mode_s2;
            mode_cnt <= '0;
        end else begin
            mode_cnt <= mode_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db_d <= 1'b0;
            changed  <= 1'b0;
            mode_q   <= '0;
        end else begin
            btn_db_d <= btn_db;
            changed  <= (mode_db != mode_q);
            mode_q   <= mode_db;
        end
    end

`ifdef START_PENDING_EN
    logic pending;

    // A changed pulse restarts the counter downstream, so it cancels any held start.
    always_ff @(posedge clk) begin
        if (rst) begin
            start   <= 1'b0;
            pending <= 1'b0;
        end else begin
            start <= ~busy & (btn_rise | (pending & ~changed));
            if (changed) begin
                pending <= 1'b0;
            end else if (pending & ~busy) begin
                pending <= 1'b0;
            end else if (btn_rise & busy) begin
                pending <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            start <= 1'b0;
        end else begin
            start <= btn_rise & ~busy;
        end
    end
`endif

endmodule

// File: tb/tb_start_change_gen.sv
// Self-checking bench for start_change_gen: exact-timing sequences, a vector table,
// and a randomized run checked every cycle against a behavioural model.
module tb_start_change_gen;

    localparam int D      = 4;
    localparam int MODE_W = 2;
`ifdef START_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              btn_start = 1'b0;
    logic [MODE_W-1:0] mode_in = '0;
    logic              busy = 1'b0;
    logic              start, changed;
    logic [MODE_W-1:0] mode_q;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [MODE_W-1:0] exp_q[$];

    start_change_gen #(.DEBOUNCE_CYCLES(D), .MODE_W(MODE_W)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .mode_in(mode_in),
        .busy(busy), .start(start), .changed(changed), .mode_q(mode_q)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_start = 1'b0; mode_in = '0; busy = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a debounced value follows the synchronised input (raw input
    // two samples old) once it has disagreed for D consecutive cycles.
    bit              m_start, m_changed, m_held;
    logic [MODE_W-1:0] m_mode_q;
    bit              b_raw[2];
    logic [MODE_W-1:0] md_raw[2];
    int              b_run, md_run;
    bit              b_deb, b_deb_old;
    logic [MODE_W-1:0] md_deb;

    always @(posedge clk) begin
        bit rise;
        if (rst) begin
            m_start = 0; m_changed = 0; m_held = 0; m_mode_q = '0;
            b_raw[0] = 0; b_raw[1] = 0; md_raw[0] = '0; md_raw[1] = '0;
            b_run = 0; md_run = 0; b_deb = 0; b_deb_old = 0; md_deb = '0;
        end else begin
            rise = b_deb && !b_deb_old;
            m_start = !busy && (rise || (PEND && m_held && !m_changed));
            if (PEND) begin
                if (m_changed || !busy) m_held = 0;
                else if (rise) m_held = 1;
            end
            m_changed = (md_deb != m_mode_q);
            m_mode_q  = md_deb;
            b_deb_old = b_deb;
            b_run  = (b_raw[1] != b_deb) ? b_run + 1 : 0;
            md_run = (md_raw[1] != md_deb) ? md_run + 1 : 0;
            if (b_run == D) begin b_deb = b_raw[1]; b_run = 0; end
            if (md_run == D) begin md_deb = md_raw[1]; md_run = 0; end
            b_raw[1] = b_raw[0]; b_raw[0] = btn_start;
            md_raw[1] = md_raw[0]; md_raw[0] = mode_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_start", int'(start), int'(m_start));
            chk("model_changed", int'(changed), int'(m_changed));
            chk("model_mode_q", int'(mode_q), int'(m_mode_q));
        end
    end

    typedef struct {
        int              width;
        logic [MODE_W-1:0] mode;
        bit              bsy;
        int              n_start;
        int              n_changed;
        logic [MODE_W-1:0] fin_mode;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int ns, nc;
        vecs[0] = '{1,  2'd0, 1'b0, 0, 0, 2'd0};
        vecs[1] = '{3,  2'd0, 1'b0, 0, 0, 2'd0};
        vecs[2] = '{4,  2'd0, 1'b0, 1, 0, 2'd0};
        vecs[3] = '{10, 2'd3, 1'b0, 1, 1, 2'd3};
        vecs[4] = '{10, 2'd1, 1'b1, 0, 1, 2'd1};
        vecs[5] = '{0,  2'd2, 1'b0, 0, 1, 2'd2};
        vecs[6] = '{0,  2'd0, 1'b0, 0, 0, 2'd0};

        tick();
        chk_en = 1'b1;
        chk("reset_start", int'(start), 0);
        chk("reset_changed", int'(changed), 0);
        chk("reset_mode_q", int'(mode_q), 0);

        // Button raised right after edge 0 and held: start only after edge 3+D.
        do_reset();
        btn_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("held_start", int'(start), int'(k == 3 + D));
            chk("held_changed", int'(changed), 0);
        end

        // Glitch of 3 cycles, then a genuine press must still debounce as a rising edge.
        do_reset();
        btn_start = 1'b1;
        tick(); tick(); tick();
        btn_start = 1'b0;
        ns = 0;
        for (int k = 0; k < 15; k++) begin tick(); ns += int'(start); end
        chk("glitch_start", ns, 0);
        btn_start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("after_glitch_start", int'(start), int'(k == 3 + D));
        end

        // Mode 0 -> 2: changed with mode_q=2 after edge 3+D; then no-op 2 -> 2.
        do_reset();
        mode_in = 2'd2;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("mode_changed", int'(changed), int'(k == 3 + D));
            if (k == 3 + D) chk("mode_q_new", int'(mode_q), 2);
        end
        nc = 0;
        for (int k = 0; k < 15; k++) begin tick(); nc += int'(changed); end
        chk("mode_same_nopulse", nc, 0);
        chk("mode_q_hold", int'(mode_q), 2);

        // Start edge while busy, busy drops later.
        do_reset();
        busy = 1'b1; btn_start = 1'b1;
        ns = 0;
        for (int k = 0; k < 20; k++) begin tick(); ns += int'(start); end
        chk("busy_nostart", ns, 0);
        busy = 1'b0;
        tick();
        chk("pending_release", int'(start), int'(PEND));
        ns = 0;
        for (int k = 0; k < 10; k++) begin tick(); ns += int'(start); end
        chk("pending_once", ns, 0);

        // Held start cancelled by a mode change.
        do_reset();
        busy = 1'b1; btn_start = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        mode_in = 2'd1;
        nc = 0;
        for (int k = 0; k < 15; k++) begin tick(); nc += int'(changed); end
        chk("cancel_changed", nc, 1);
        busy = 1'b0;
        ns = 0;
        for (int k = 0; k < 10; k++) begin tick(); ns += int'(start); end
        chk("cancel_nostart", ns, 0);

        // Reset while the button counter sits at 2, button kept high.
        do_reset();
        btn_start = 1'b1;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("rst_mid_start", int'(start), int'(k == 3 + D));
        end

        // Vector table.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            mode_in = vecs[i].mode; busy = vecs[i].bsy;
            exp_q.push_back(vecs[i].fin_mode);
            ns = 0; nc = 0;
            for (int k = 0; k < 25; k++) begin
                btn_start = (k < vecs[i].width);
                tick();
                ns += int'(start); nc += int'(changed);
            end
            chk("vec_starts", ns, vecs[i].n_start);
            chk("vec_changes", nc, vecs[i].n_changed);
            chk("vec_mode_q", int'(mode_q), int'(exp_q.pop_front()));
        end

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 9) == 0) mode_in = MODE_W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) busy = ~busy;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
